// File: rtl/cell_array_pkg.sv
// Shared types for the cell_array micro-op sequencer: command opcodes,
// sequencer states and one-hot full-adder operation encodings.
// Purely declarative; no logic, no latency.
package cell_array_pkg;

  // Command opcodes as presented on cmd_op
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_INC  = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_OR   = 3'd5,
    OP_LOAD = 3'd6,
    OP_READ = 3'd7
  } cmd_op_e;

  // Sequencer states; every array command walks READ -> EXEC -> RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

  // One-hot full-adder operation selects driven on arr_op_fa
  localparam logic [3:0] FA_NONE = 4'b0000;
  localparam logic [3:0] FA_SUM  = 4'b0001;
  localparam logic [3:0] FA_AND  = 4'b0010;
  localparam logic [3:0] FA_XOR  = 4'b0100;
  localparam logic [3:0] FA_OR   = 4'b1000;

  // Array FA operation for a command; LOAD/READ/NOP use the plain write path
  function automatic logic [3:0] fa_sel(cmd_op_e op);
    case (op)
      OP_ADD, OP_INC: return FA_SUM;
      OP_AND:         return FA_AND;
      OP_XOR:         return FA_XOR;
      OP_OR:          return FA_OR;
      default:        return FA_NONE;
    endcase
  endfunction

  // Commands that write their destination row
  function automatic logic writes_dst(cmd_op_e op);
    return op inside {OP_ADD, OP_INC, OP_AND, OP_XOR, OP_OR, OP_LOAD};
  endfunction

  // Commands whose response reports the adder overflow of the destination row
  function automatic logic reports_ovf(cmd_op_e op);
    return op inside {OP_ADD, OP_INC};
  endfunction

endpackage

// File: rtl/cell_array_seq_onehot_dec.sv
// Row index to one-hot select decoder for the array address buses.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is all-zero when disabled or index is out of range.
module onehot_dec #(
  parameter int ROWS = 32,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic [AW-1:0]   idx,
  input  logic            en,
  output logic [ROWS-1:0] onehot
);

  // Decode a single row select; out-of-range indices never produce a select
  always_comb begin
    onehot = '0;
    if (en && (32'(idx) < ROWS)) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cell_array_seq.sv
// Micro-op sequencer: decodes one command into cell_array selects and returns a response.
// Latency: accept at edge T, READ T..T+1, EXEC T+1..T+2, rsp_valid from T+2 (illegal/NOP: from T).
// Backpressure: single command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module cell_array_seq
  import cell_array_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [AW-1:0]   cmd_src_a,
  input  logic [AW-1:0]   cmd_src_b,
  input  logic [AW-1:0]   cmd_dst,
  input  logic [COLS-1:0] cmd_data,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_ovf,
  output logic            rsp_msb,
  output logic            rsp_err,

  output logic [ROWS-1:0] arr_rd_addr_up,
  output logic [ROWS-1:0] arr_rd_addr_dn,
  output logic [ROWS-1:0] arr_wr_addr_up,
  output logic [ROWS-1:0] arr_wr_addr_dn,
  output logic [ROWS-1:0] arr_wr_en,
  output logic [3:0]      arr_op_fa,
  output logic            arr_carry_in,
  output logic [COLS-1:0] arr_data_in_up,
  output logic [COLS-1:0] arr_data_in_dn,
  input  logic [COLS-1:0] arr_rd_out_up,
  input  logic [ROWS-1:0] arr_overflow,
  input  logic            arr_last_row_msb
);

  seq_state_e state, state_nxt;

  // Latched command
  cmd_op_e         op_q;
  logic [AW-1:0]   src_a_q;
  logic [AW-1:0]   src_b_q;
  logic [AW-1:0]   dst_q;
  logic [COLS-1:0] data_q;

  // Response registers
  logic            err_q;
  logic [COLS-1:0] rsp_data_q;
  logic            ovf_q;
  logic            msb_q;
  logic            msb_first_q;

  // Decoded command on the input side, used only while IDLE
  cmd_op_e cmd_op_in;
  logic    idx_oob;
  logic    cmd_illegal;
  logic    cmd_skip;

  // Array control intent, turned into one-hot selects by the decoders
  logic    rd_en;
  logic    wr_en;

  // Classify the offered command: out-of-range rows or a write to row 0 are illegal
  always_comb begin
    cmd_op_in   = cmd_op_e'(cmd_op);
    idx_oob     = (32'(cmd_src_a) >= ROWS) ||
                  (32'(cmd_src_b) >= ROWS) ||
                  (32'(cmd_dst)   >= ROWS);
    cmd_illegal = idx_oob || (writes_dst(cmd_op_in) && (cmd_dst == '0));
    // Illegal commands and NOPs never touch the array and respond straight away
    cmd_skip    = cmd_illegal || (cmd_op_in == OP_NOP);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed READ -> EXEC -> RESP walk, RESP waits for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_skip ? ST_RESP : ST_READ;
        end
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: array controls live only in READ/EXEC, handshakes follow the state
  always_comb begin
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    arr_op_fa      = FA_NONE;
    arr_carry_in   = 1'b0;
    arr_data_in_up = '0;
    arr_data_in_dn = '0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_READ: rd_en = 1'b1;
      ST_EXEC: begin
        // LOAD writes the immediate, so no row needs to be driven onto the buses
        rd_en        = (op_q != OP_LOAD);
        // Row 0 is hard-wired zero; never strobe it even if a bad dst slipped in
        wr_en        = writes_dst(op_q) && (dst_q != '0);
        arr_op_fa    = fa_sel(op_q);
        arr_carry_in = (op_q == OP_INC);
        if (op_q == OP_LOAD) begin
          arr_data_in_up = data_q;
          arr_data_in_dn = data_q;
        end
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command latch and response capture points (read data, overflow, last-row MSB)
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_NOP;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      ovf_q       <= 1'b0;
      msb_q       <= 1'b0;
      msb_first_q <= 1'b0;
    end else begin
      // Marks the first RESP cycle after EXEC, when the last-row MSB is post-write
      msb_first_q <= (state == ST_EXEC);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op_in;
            src_a_q    <= cmd_src_a;
            src_b_q    <= cmd_src_b;
            dst_q      <= cmd_dst;
            data_q     <= cmd_data;
            err_q      <= cmd_illegal;
            rsp_data_q <= '0;
            ovf_q      <= 1'b0;
            msb_q      <= 1'b0;
          end
        end
        ST_READ: begin
          if (op_q == OP_READ) begin
            rsp_data_q <= arr_rd_out_up;
          end
        end
        ST_EXEC: begin
          ovf_q <= reports_ovf(op_q) && arr_overflow[dst_q];
        end
        ST_RESP: begin
          // Freeze the MSB seen on RESP entry so it stays stable while stalled
          if (msb_first_q) begin
            msb_q <= arr_last_row_msb;
          end
        end
        default: ;
      endcase
    end
  end

  // Response fields read as zero whenever no response is being offered
  always_comb begin
    rsp_data = '0;
    rsp_ovf  = 1'b0;
    rsp_msb  = 1'b0;
    rsp_err  = 1'b0;
    if (state == ST_RESP) begin
      rsp_data = rsp_data_q;
      rsp_ovf  = ovf_q;
      rsp_err  = err_q;
      rsp_msb  = msb_first_q ? arr_last_row_msb : msb_q;
    end
  end

  onehot_dec #(.ROWS(ROWS), .AW(AW)) u_dec_rd_up (
    .idx    (src_a_q),
    .en     (rd_en),
    .onehot (arr_rd_addr_up)
  );

  onehot_dec #(.ROWS(ROWS), .AW(AW)) u_dec_rd_dn (
    .idx    (src_b_q),
    .en     (rd_en),
    .onehot (arr_rd_addr_dn)
  );

  onehot_dec #(.ROWS(ROWS), .AW(AW)) u_dec_wr (
    .idx    (dst_q),
    .en     (wr_en),
    .onehot (arr_wr_en)
  );

  // Both write ports target the same destination row
  assign arr_wr_addr_up = arr_wr_en;
  assign arr_wr_addr_dn = arr_wr_en;

endmodule

// File: tb/tb_cell_array_seq.sv
// Directed bench for cell_array_seq with a behavioural cell_array model behind it.
// Latency: checks accept-to-response spacing per command class.
// Backpressure: exercises held rsp_ready and reset during EXEC.
module tb_cell_array_seq;
  import cell_array_pkg::*;

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [AW-1:0]   cmd_src_a, cmd_src_b, cmd_dst;
  logic [COLS-1:0] cmd_data;
  logic            rsp_valid, rsp_ready;
  logic [COLS-1:0] rsp_data;
  logic            rsp_ovf, rsp_msb, rsp_err;
  logic [ROWS-1:0] arr_rd_addr_up, arr_rd_addr_dn, arr_wr_addr_up, arr_wr_addr_dn, arr_wr_en;
  logic [3:0]      arr_op_fa;
  logic            arr_carry_in;
  logic [COLS-1:0] arr_data_in_up, arr_data_in_dn, arr_rd_out_up;
  logic [ROWS-1:0] arr_overflow;
  logic            arr_last_row_msb;

  always #5 clk = ~clk;

  cell_array_seq #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_msb(rsp_msb), .rsp_err(rsp_err),
    .arr_rd_addr_up(arr_rd_addr_up), .arr_rd_addr_dn(arr_rd_addr_dn),
    .arr_wr_addr_up(arr_wr_addr_up), .arr_wr_addr_dn(arr_wr_addr_dn),
    .arr_wr_en(arr_wr_en), .arr_op_fa(arr_op_fa), .arr_carry_in(arr_carry_in),
    .arr_data_in_up(arr_data_in_up), .arr_data_in_dn(arr_data_in_dn),
    .arr_rd_out_up(arr_rd_out_up), .arr_overflow(arr_overflow),
    .arr_last_row_msb(arr_last_row_msb)
  );

  // ---------------- behavioural cell_array ----------------
  logic [COLS-1:0] mem [ROWS];
  logic            mem_clr;
  logic [COLS-1:0] rd_up, rd_dn, wval;
  logic [COLS:0]   sum;

  always_comb begin
    rd_up = '0;
    rd_dn = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (arr_rd_addr_up[i]) rd_up = rd_up | mem[i];
      if (arr_rd_addr_dn[i]) rd_dn = rd_dn | mem[i];
    end
    sum = {1'b0, rd_up} + {1'b0, rd_dn} + {{COLS{1'b0}}, arr_carry_in};
    case (arr_op_fa)
      4'b0001: wval = sum[COLS-1:0];
      4'b0010: wval = rd_up & rd_dn;
      4'b0100: wval = rd_up ^ rd_dn;
      4'b1000: wval = rd_up | rd_dn;
      default: wval = arr_data_in_up;
    endcase
  end

  assign arr_rd_out_up    = rd_up;
  assign arr_overflow     = (arr_op_fa == 4'b0001 && sum[COLS]) ? arr_wr_en : '0;
  assign arr_last_row_msb = mem[ROWS-1][COLS-1];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < ROWS; i++) if (arr_wr_en[i]) mem[i] <= wval;
    end
  end

  // ---------------- per-cycle monitor ----------------
  int              wr_cnt = 0, cin_cnt = 0, rsp_cnt = 0, bad_cnt = 0;
  logic [ROWS-1:0] last_wr = '0;
  logic [COLS-1:0] last_din = '0;
  logic [3:0]      last_fa = '0;

  always @(negedge clk) begin
    if ($countones(arr_wr_en) > 1 || $countones(arr_rd_addr_up) > 1 ||
        $countones(arr_rd_addr_dn) > 1 || $countones(arr_op_fa) > 1 ||
        arr_wr_addr_up != arr_wr_en || arr_wr_addr_dn != arr_wr_en ||
        arr_data_in_dn != arr_data_in_up || arr_wr_en[0] ||
        (arr_carry_in && arr_op_fa != 4'b0001))
      bad_cnt <= bad_cnt + 1;
    if (|arr_wr_en) begin
      wr_cnt   <= wr_cnt + 1;
      last_wr  <= arr_wr_en;
      last_din <= arr_data_in_up;
      last_fa  <= arr_op_fa;
    end
    if (arr_carry_in) cin_cnt <= cin_cnt + 1;
    if (rsp_valid)    rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one command, wait (bounded) for its response, optionally stall it, then consume it
  task automatic do_cmd(input cmd_op_e op, input int a, input int b, input int d,
                        input logic [COLS-1:0] data, input int hold,
                        output logic [COLS-1:0] r_data, output logic r_ovf,
                        output logic r_msb, output logic r_err,
                        output int lat, output int wrs, output int cins);
    int  w0, c0;
    bit  seen;
    @(negedge clk);
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    w0 = wr_cnt; c0 = cin_cnt;
    cmd_valid = 1'b1; cmd_op = op;
    cmd_src_a = AW'(a); cmd_src_b = AW'(b); cmd_dst = AW'(d); cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    if (!seen) check_eq("rsp_timeout", 64'(0), 64'(1));
    r_data = rsp_data; r_ovf = rsp_ovf; r_msb = rsp_msb; r_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("stall_stable", 64'({rsp_valid, cmd_ready, rsp_err, rsp_ovf, rsp_msb, rsp_data}),
               64'({1'b1, 1'b0, r_err, r_ovf, r_msb, r_data}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    wrs = wr_cnt - w0; cins = cin_cnt - c0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [COLS-1:0] d;
    logic            o, m, e;
    int              lat, w, c, w0, r0;

    rst = 1'b1; mem_clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 64'({cmd_ready, rsp_valid, rsp_err, rsp_ovf, rsp_msb, arr_carry_in, arr_op_fa}),
             64'(10'b10_0000_0000));
    check_eq("rst_sel", 64'(arr_rd_addr_up | arr_rd_addr_dn | arr_wr_addr_up | arr_wr_addr_dn | arr_wr_en), 64'(0));
    check_eq("rst_dat", 64'(rsp_data | arr_data_in_up | arr_data_in_dn), 64'(0));
    rst = 1'b0; mem_clr = 1'b0;

    // LOAD r5 = 0xFF
    do_cmd(OP_LOAD, 0, 0, 5, 32'h0000_00FF, 0, d, o, m, e, lat, w, c);
    check_eq("load_lat", 64'(lat), 64'(3));
    check_eq("load_wr_cycles", 64'(w), 64'(1));
    check_eq("load_wr_row", 64'(last_wr), 64'(32'd1 << 5));
    check_eq("load_din", 64'(last_din), 64'(32'hFF));
    check_eq("load_err", 64'(e), 64'(0));

    // ADD r7 = r5 + r6 overflowing to zero
    do_cmd(OP_LOAD, 0, 0, 5, 32'hFFFF_FFFF, 0, d, o, m, e, lat, w, c);
    do_cmd(OP_LOAD, 0, 0, 6, 32'h0000_0001, 0, d, o, m, e, lat, w, c);
    do_cmd(OP_ADD, 5, 6, 7, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("add_fa", 64'(last_fa), 64'(4'b0001));
    check_eq("add_ovf", 64'(o), 64'(1));
    check_eq("add_cin", 64'(c), 64'(0));
    do_cmd(OP_READ, 7, 5, 0, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("read_r7", 64'(d), 64'(0));
    check_eq("read_lat", 64'(lat), 64'(3));
    check_eq("read_no_wr", 64'(w), 64'(0));
    check_eq("read_ovf", 64'(o), 64'(0));

    // INC r6 = r6 + r0 + 1
    do_cmd(OP_INC, 6, 0, 6, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("inc_cin_cycles", 64'(c), 64'(1));
    check_eq("inc_fa", 64'(last_fa), 64'(4'b0001));
    check_eq("inc_ovf", 64'(o), 64'(0));
    do_cmd(OP_READ, 6, 0, 0, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("read_r6", 64'(d), 64'(2));

    // LOAD to row 0 is illegal
    do_cmd(OP_LOAD, 0, 0, 0, 32'h0000_1234, 0, d, o, m, e, lat, w, c);
    check_eq("ill_err", 64'(e), 64'(1));
    check_eq("ill_no_wr", 64'(w), 64'(0));
    check_eq("ill_lat", 64'(lat), 64'(1));
    do_cmd(OP_READ, 0, 0, 0, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("read_r0", 64'({e, d}), 64'(0));

    // Last row MSB follows the write made in EXEC
    do_cmd(OP_LOAD, 0, 0, ROWS-1, 32'h8000_0000, 0, d, o, m, e, lat, w, c);
    check_eq("msb_set", 64'(m), 64'(1));
    do_cmd(OP_XOR, ROWS-1, ROWS-1, ROWS-1, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("msb_clr", 64'(m), 64'(0));
    check_eq("xor_fa", 64'(last_fa), 64'(4'b0100));

    // AND / OR
    do_cmd(OP_LOAD, 0, 0, 8, 32'h0000_F0F0, 0, d, o, m, e, lat, w, c);
    do_cmd(OP_LOAD, 0, 0, 9, 32'h0000_FF00, 0, d, o, m, e, lat, w, c);
    do_cmd(OP_AND, 8, 9, 10, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("and_fa", 64'(last_fa), 64'(4'b0010));
    do_cmd(OP_READ, 10, 0, 0, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("read_and", 64'(d), 64'(32'h0000_F000));
    do_cmd(OP_OR, 8, 9, 11, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("or_fa", 64'(last_fa), 64'(4'b1000));
    do_cmd(OP_READ, 11, 0, 0, 32'h0, 0, d, o, m, e, lat, w, c);
    check_eq("read_or", 64'(d), 64'(32'h0000_FFF0));

    // NOP: immediate all-zero response, no writes
    do_cmd(OP_NOP, 3, 4, 5, 32'hDEAD_BEEF, 0, d, o, m, e, lat, w, c);
    check_eq("nop_fields", 64'({e, o, m, d}), 64'(0));
    check_eq("nop_lat", 64'(lat), 64'(1));
    check_eq("nop_no_wr", 64'(w), 64'(0));

    // Aliased ADD uses pre-write operands
    do_cmd(OP_ADD, 9, 9, 9, 32'h0, 0, d, o, m, e, lat, w, c);
    // Stalled READ: response must hold for 5 cycles
    do_cmd(OP_READ, 9, 0, 0, 32'h0, 5, d, o, m, e, lat, w, c);
    check_eq("read_alias", 64'(d), 64'(32'h0001_FE00));
    check_eq("ready_after_rsp", 64'(cmd_ready), 64'(1));

    // Reset during EXEC abandons the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src_a = 5'd5; cmd_src_b = 5'd6; cmd_dst = 5'd12;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("exec_wr_row", 64'(arr_wr_en), 64'(32'd1 << 12));
    rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("midrst_ctl", 64'({cmd_ready, rsp_valid, rsp_err, rsp_ovf, rsp_msb, arr_carry_in, arr_op_fa}),
             64'(10'b10_0000_0000));
    check_eq("midrst_sel", 64'(arr_rd_addr_up | arr_rd_addr_dn | arr_wr_en | arr_data_in_up | rsp_data), 64'(0));
    rst = 1'b0;
    w0 = wr_cnt; r0 = rsp_cnt;
    repeat (8) @(negedge clk);
    check_eq("midrst_no_rsp", 64'(rsp_cnt - r0), 64'(0));
    check_eq("midrst_no_wr", 64'(wr_cnt - w0), 64'(0));
    rsp_ready = 1'b0;

    check_eq("onehot_violations", 64'(bad_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
